// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word-aligned fetches, buffers
// in-order responses with their PCs and hands them to decode; redirects flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]      pc;
  logic [31:0]      buf_pc    [DEPTH];
  logic [31:0]      buf_instr [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PW-1:0]    head, tail, fill_ptr;
  logic [CW-1:0]    occ, pend, drop_cnt;
  logic [CW:0]      inflight, drop_sum;
  logic [CW-1:0]    drop_after_redirect;
  logic             req_fire, pop, rsp_fill, rsp_drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight       = {1'b0, occ} + {1'b0, drop_cnt};
    // Gating with rst_n keeps the request low for the whole reset window.
    imem_req_valid = rst_n && !redirect_valid && (inflight < (CW+1)'(DEPTH));
    imem_req_addr  = pc;
    id_valid       = !redirect_valid && (occ != '0) && filled[head];
    id_instr       = id_valid ? buf_instr[head] : '0;
    id_pc          = id_valid ? buf_pc[head] : '0;
    req_fire       = imem_req_valid && imem_req_ready;
    pop            = id_valid && id_ready;
    rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
    rsp_fill       = imem_rsp_valid && (drop_cnt == '0) && (pend != '0);
    // Every unfilled entry becomes a stale in-flight response, minus the one landing now.
    drop_sum       = {1'b0, drop_cnt} + {1'b0, pend};
    drop_after_redirect = (imem_rsp_valid && (drop_sum != '0)) ? CW'(drop_sum - 1'b1)
                                                                : CW'(drop_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      occ      <= '0;
      pend     <= '0;
      drop_cnt <= '0;
      filled   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc       <= {redirect_pc[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      occ      <= '0;
      pend     <= '0;
      filled   <= '0;
      drop_cnt <= drop_after_redirect;
    end else begin
      if (req_fire) begin
        buf_pc[tail] <= pc;
        filled[tail] <= 1'b0;
        tail         <= ptr_inc(tail);
        pc           <= pc + 32'd4;
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
      if (rsp_fill) begin
        buf_instr[fill_ptr] <= imem_rsp_data;
        filled[fill_ptr]    <= 1'b1;
        fill_ptr            <= ptr_inc(fill_ptr);
      end
      if (pop) begin
        filled[head] <= 1'b0;
        head         <= ptr_inc(head);
      end
      occ  <= occ + CW'(req_fire) - CW'(pop);
      pend <= pend + CW'(req_fire) - CW'(rsp_fill);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: an in-order memory model plus a
// program-order reference of which fetched PCs must reach decode.
module tb_fetch_stage;

  localparam logic [31:0] RPC   = 32'h0000_1000;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid, id_ready = 1'b0;
  logic [31:0] id_instr, id_pc;

  fetch_stage #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] data; int unsigned due; } mem_t;

  exp_t        expq[$];   // fetched, not yet decoded, still architecturally live
  mem_t        memq[$];   // accepted requests awaiting a memory response
  logic [31:0] model_pc = RPC;
  int unsigned stale = 0; // responses owed for requests killed by a redirect
  int unsigned cyc = 0;
  int unsigned lat_max = 0;
  int unsigned fires = 0;
  int unsigned passed = 0, total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Request side: checks issue gating/address, pushes expectations, models memory.
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_rv;
      exp_rv = !redirect_valid && ((expq.size() + stale) < DEPTH);
      check("req_valid", imem_req_valid, exp_rv);
      if (redirect_valid) check("id_valid_in_redirect", id_valid, 1'b0);
      else if (imem_req_valid) check("req_addr", imem_req_addr, model_pc);

      if (imem_rsp_valid) begin
        assert (memq.size() > 0) else $error("FAIL rsp_without_outstanding");
        if (memq.size() > 0) void'(memq.pop_front());
        if (!redirect_valid && stale > 0) stale--;
      end

      if (redirect_valid) begin
        expq.delete();
        stale    = memq.size();
        model_pc = {redirect_pc[31:2], 2'b00};
      end else if (imem_req_valid && imem_req_ready) begin
        expq.push_back('{pc: model_pc, instr: mem_word(model_pc)});
        memq.push_back('{data: mem_word(imem_req_addr), due: cyc + 1 + $urandom_range(lat_max, 0)});
        model_pc += 32'd4;
        fires++;
      end
    end
  end

  // Decode side: compares whatever decode is shown against the oldest live fetch.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (!id_valid) begin
        check("id_instr_idle", id_instr, '0);
        check("id_pc_idle", id_pc, '0);
      end else if (expq.size() == 0) begin
        check("unexpected_decode_pc", id_pc, 32'hFFFF_FFFF);
      end else begin
        check("id_pc", id_pc, expq[0].pc);
        check("id_instr", id_instr, expq[0].instr);
        if (id_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic step(input logic idr, input logic rqr, input logic redir, input logic [31:0] rpc);
    @(posedge clk); #1;
    id_ready       = idr;
    imem_req_ready = rqr;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic drained(input string tag);
    #2;
    check({tag, "_expq_empty"}, expq.size(), 0);
    check({tag, "_memq_empty"}, memq.size(), 0);
    check({tag, "_no_stale"}, stale, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_id_instr", id_instr, '0);
    check("rst_id_pc", id_pc, '0);

    // Decode stalled from the first fetch: only DEPTH requests may go out.
    rst_n = 1'b1; id_ready = 1'b0; imem_req_ready = 1'b1;
    fires = 0;
    repeat (10) step(1'b0, 1'b1, 1'b0, '0);
    #2;
    check("bp_fire_count", fires, DEPTH);
    check("bp_id_valid", id_valid, 1'b1);
    check("bp_id_pc", id_pc, RPC);
    repeat (10) step(1'b1, 1'b1, 1'b0, '0);

    // Mixed stalls, latencies and redirects (unaligned targets included).
    lat_max = 2;
    for (int i = 0; i < 2000; i++)
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0, $urandom);

    lat_max = 0;
    repeat (30) step(1'b1, 1'b0, 1'b0, '0);
    drained("drain1");

    // Async reset with a full buffer.
    repeat (6) step(1'b0, 1'b1, 1'b0, '0);
    #2;
    check("pre_reset_id_valid", id_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_id_valid", id_valid, 1'b0);
    check("async_rst_req_valid", imem_req_valid, 1'b0);
    expq.delete(); memq.delete();
    stale = 0; model_pc = RPC;
    imem_rsp_valid = 1'b0;
    repeat (2) step(1'b1, 1'b1, 1'b0, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #4;
    check("restart_addr", imem_req_addr, RPC);
    repeat (20) step(1'b1, 1'b1, 1'b0, '0);
    repeat (30) step(1'b1, 1'b0, 1'b0, '0);
    drained("drain2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
